// File: rtl/io_write_arbiter_if.sv
// io_write_arbiter_if: CPU store path, UART byte strobes and I/O bank write port
// shared by the write arbiter (slave) and whoever drives the requests (master).
interface io_write_arbiter_if #(
    parameter int N = 5,
    parameter int T = 8
);
    logic         cpu_req;
    logic [N-1:0] cpu_addr;
    logic [T-1:0] cpu_data;
    logic         cpu_ack;
    logic         rx_valid;
    logic [T-1:0] rx_data;
    logic [N-1:0] rx_addr;
    logic         ovf_clr;
    logic         rx_overflow;
    logic         habilitar;
    logic [N-1:0] entradaDeco;
    logic [T-1:0] data_IO_in;
    logic         busy;
    logic         addr_err;

    modport slave (
        input  cpu_req, cpu_addr, cpu_data, rx_valid, rx_data, rx_addr, ovf_clr,
        output cpu_ack, rx_overflow, habilitar, entradaDeco, data_IO_in, busy, addr_err
    );

    modport master (
        output cpu_req, cpu_addr, cpu_data, rx_valid, rx_data, rx_addr, ovf_clr,
        input  cpu_ack, rx_overflow, habilitar, entradaDeco, data_IO_in, busy, addr_err
    );
endinterface

// File: rtl/io_write_arbiter.sv
// io_write_arbiter: round-robin owner of the I/O bank write port (CPU vs buffered UART bytes).
// Define IO_ARB_ADDR_CHECK_EN to suppress writes to indices >= R and flag them on addr_err.
module io_write_arbiter #(
    parameter int R          = 2,
    parameter int N          = 5,
    parameter int T          = 8,
    parameter int FIFO_DEPTH = 2
) (
    input logic clk,
    input logic rst,
    io_write_arbiter_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef IO_ARB_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef enum logic {IDLE, WRITE} state_t;

    state_t        state, state_n;
    logic          last_rx;
    logic [T-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          hab_q, ack_q, err_q, ovf_q;
    logic [N-1:0]  addr_q, addr_sel;
    logic [T-1:0]  data_q, data_sel;
    logic          fifo_ne, full, pick_cpu, pick_rx, grant, pop, push, ovf, bad;

    always_comb begin
        fifo_ne  = count != '0;
        full     = count == (AW+1)'(FIFO_DEPTH);
        pick_cpu = bus.cpu_req && (!fifo_ne || last_rx);
        pick_rx  = fifo_ne && (!bus.cpu_req || !last_rx);
        grant    = state == IDLE && (pick_cpu || pick_rx);
        pop      = grant && pick_rx;
        addr_sel = pick_cpu ? bus.cpu_addr : bus.rx_addr;
        data_sel = pick_cpu ? bus.cpu_data : mem[rd_ptr];
        bad      = CHK && 32'(addr_sel) >= R;
        // a pop on the same edge frees the slot the incoming byte needs
        push     = bus.rx_valid && (!full || pop);
        ovf      = bus.rx_valid && !push;
        state_n  = grant ? WRITE : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_rx <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            hab_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            hab_q <= grant && !bad;
            ack_q <= grant && pick_cpu;
            err_q <= grant && bad;
            if (grant) begin
                addr_q  <= addr_sel;
                data_q  <= data_sel;
                last_rx <= pick_rx;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            ovf_q <= ovf || (ovf_q && !bus.ovf_clr);
        end
    end

    assign bus.habilitar   = hab_q;
    assign bus.cpu_ack     = ack_q;
    assign bus.addr_err    = err_q;
    assign bus.entradaDeco = addr_q;
    assign bus.data_IO_in  = data_q;
    assign bus.rx_overflow = ovf_q;
    assign bus.busy        = state == WRITE || fifo_ne;
endmodule

// File: tb/tb_io_write_arbiter.sv
// tb_io_write_arbiter: directed stimulus with a write scoreboard; a negedge monitor
// pops one expected write per observed write cycle (habilitar, cpu_ack or addr_err).
module tb_io_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    io_write_arbiter_if #(.N(5), .T(8)) bus ();
    io_write_arbiter #(.R(2), .N(5), .T(8), .FIFO_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct packed {
        logic [4:0] a;
        logic [7:0] d;
        logic       cpu;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expw(input logic [4:0] a, input logic [7:0] d, input logic cpu, input logic err);
        sb.push_back({a, d, cpu, err});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_hab"}, 32'(bus.habilitar), 0);
        chk({p, "_ack"}, 32'(bus.cpu_ack), 0);
        chk({p, "_err"}, 32'(bus.addr_err), 0);
        chk({p, "_deco"}, 32'(bus.entradaDeco), 0);
        chk({p, "_data"}, 32'(bus.data_IO_in), 0);
        chk({p, "_busy"}, 32'(bus.busy), 0);
        chk({p, "_ovf"}, 32'(bus.rx_overflow), 0);
    endtask

    always @(negedge clk) begin
        if (bus.habilitar || bus.cpu_ack || bus.addr_err) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {29'd0, bus.habilitar, bus.cpu_ack, bus.addr_err}, 0);
            end else begin
                e = sb.pop_front();
                chk("wr_hab", 32'(bus.habilitar), 32'(!e.err));
                chk("wr_ack", 32'(bus.cpu_ack), 32'(e.cpu));
                chk("wr_err", 32'(bus.addr_err), 32'(e.err));
                chk("wr_deco", 32'(bus.entradaDeco), 32'(e.a));
                chk("wr_data", 32'(bus.data_IO_in), 32'(e.d));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cpu_req = 0; bus.cpu_addr = 0; bus.cpu_data = 0;
        bus.rx_valid = 0; bus.rx_data = 0; bus.rx_addr = 0; bus.ovf_clr = 0;
        rst = 0;
        tick(3);
        chk_reset("rst0");
        rst = 1;
        tick(1);

        // single CPU write, one-cycle latency and one-cycle pulse
        expw(5'd1, 8'hA5, 1, 0);
        bus.cpu_req = 1; bus.cpu_addr = 5'd1; bus.cpu_data = 8'hA5;
        tick(1);
        chk("cpu_lat_hab", 32'(bus.habilitar), 1);
        chk("cpu_lat_ack", 32'(bus.cpu_ack), 1);
        bus.cpu_req = 0;
        tick(1);
        chk("cpu_pulse_end", 32'(bus.habilitar), 0);
        tick(2);

        // reset while WRITE and FIFO holding two bytes
        expw(5'd1, 8'h99, 1, 0);
        expw(5'd0, 8'h51, 0, 0);
        bus.cpu_req = 1; bus.cpu_addr = 5'd1; bus.cpu_data = 8'h99;
        bus.rx_valid = 1; bus.rx_data = 8'h51; bus.rx_addr = 5'd0;
        tick(1);
        bus.cpu_req = 0; bus.rx_data = 8'h52;
        tick(1);
        bus.rx_data = 8'h53;
        tick(1);
        bus.rx_valid = 0;
        chk("busy_mid_write", 32'(bus.busy), 1);
        rst = 0;
        tick(1);
        chk_reset("rst1");
        rst = 1;
        expw(5'd0, 8'h61, 0, 0);
        bus.rx_valid = 1; bus.rx_data = 8'h61;
        tick(1);
        bus.rx_valid = 0;
        tick(4);

        // alternation with cpu_req held and bytes queued; tie goes to CPU
        expw(5'd1, 8'hC1, 1, 0);
        expw(5'd0, 8'h11, 0, 0);
        expw(5'd1, 8'hC1, 1, 0);
        expw(5'd0, 8'h22, 0, 0);
        bus.rx_valid = 1; bus.rx_data = 8'h11;
        tick(1);
        bus.rx_data = 8'h22; bus.cpu_req = 1; bus.cpu_addr = 5'd1; bus.cpu_data = 8'hC1;
        tick(1);
        bus.rx_valid = 0;
        tick(4);
        bus.cpu_req = 0;
        tick(4);

        // three consecutive strobes, third lands on a full FIFO with no pop
        expw(5'd0, 8'h30, 0, 0);
        expw(5'd1, 8'h5A, 1, 0);
        expw(5'd0, 8'h31, 0, 0);
        expw(5'd0, 8'h32, 0, 0);
        bus.rx_valid = 1; bus.rx_data = 8'h30;
        tick(1);
        bus.rx_valid = 0;
        tick(1);
        bus.rx_valid = 1; bus.rx_data = 8'h31;
        tick(1);
        bus.rx_data = 8'h32; bus.cpu_req = 1; bus.cpu_addr = 5'd1; bus.cpu_data = 8'h5A;
        tick(1);
        chk("ovf_before", 32'(bus.rx_overflow), 0);
        bus.rx_data = 8'h33; bus.cpu_req = 0;
        tick(1);
        bus.rx_valid = 0;
        chk("ovf_set", 32'(bus.rx_overflow), 1);
        tick(5);
        chk("ovf_sticky", 32'(bus.rx_overflow), 1);
        bus.ovf_clr = 1;
        tick(1);
        bus.ovf_clr = 0;
        chk("ovf_cleared", 32'(bus.rx_overflow), 0);
        tick(2);

        // push on the same edge as an RX grant with the FIFO full
        expw(5'd1, 8'h6B, 1, 0);
        expw(5'd0, 8'h41, 0, 0);
        expw(5'd0, 8'h42, 0, 0);
        expw(5'd0, 8'h43, 0, 0);
        bus.cpu_req = 1; bus.cpu_addr = 5'd1; bus.cpu_data = 8'h6B;
        bus.rx_valid = 1; bus.rx_data = 8'h41;
        tick(1);
        bus.cpu_req = 0; bus.rx_data = 8'h42;
        tick(1);
        bus.rx_data = 8'h43;
        tick(1);
        bus.rx_valid = 0;
        chk("ovf_same_edge", 32'(bus.rx_overflow), 0);
        chk("busy_draining", 32'(bus.busy), 1);
        tick(6);
        chk("busy_idle", 32'(bus.busy), 0);

        // out-of-range address
`ifdef IO_ARB_ADDR_CHECK_EN
        expw(5'd3, 8'h77, 1, 1);
`else
        expw(5'd3, 8'h77, 1, 0);
`endif
        bus.cpu_req = 1; bus.cpu_addr = 5'd3; bus.cpu_data = 8'h77;
        tick(1);
        bus.cpu_req = 0;
        tick(3);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
